sram_march_bist: RTL
====================

# sram_march_bist

Built-in self-test sequencer for the OpenRAM macros on the testchip. It takes ownership of the shared SRAM port-0 bus (addr0/din0/web0/wmask0/csb0), which is muxed in ahead of the existing control logic. It runs a March C- pattern on one selected macro, compares port-0 read data against expected values, and reports pass/fail, the first failing address and data, and a failure count. One instance serves all macros; only one macro is tested per run.

## Interface
Parameters:
- ADDR_SIZE, 16: port-0 address width.
- DATA_SIZE, 32: data width.
- WMASK_SIZE, 4: write-mask width.
- MAX_CHIPS, 16: number of csb0 lines.
- RD_LAT, 1: cycles from a read being driven to its dout0 being valid at `sram_dout`, range 1–3.

Ports:
- clk  in  1  clock (already decided).
- rstn  in  1  reset; synchronous, active-low (already decided).
- start  in  1  single-cycle pulse; begins a run when idle.
- abort  in  1  terminates a run; highest priority after reset.
- sram_sel  in  4  macro index under test.
- addr_max  in  ADDR_SIZE  highest address to test (depth-1).
- pattern  in  DATA_SIZE  background pattern bg.
- sram_dout  in  DATA_SIZE  port-0 read data of the selected macro (muxed externally).
- addr0  out  ADDR_SIZE  port-0 address.
- din0  out  DATA_SIZE  port-0 write data.
- web0  out  1  active-low write enable.
- wmask0  out  WMASK_SIZE  write mask; all ones while busy.
- csb0  out  MAX_CHIPS  active-low chip selects.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next accepted start.
- pass  out  1  valid when done; 1 means zero miscompares.
- fail_addr  out  ADDR_SIZE  address of the first miscompare.
- fail_data  out  DATA_SIZE  read data at the first miscompare.
- fail_count  out  16  miscompare count, saturating at 16'hFFFF.

## Operation
- States: IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE.
- Elements, with N = addr_max+1:
  - M0 ↑ w(bg)
  - M1 ↑ r(bg),w(~bg)
  - M2 ↑ r(~bg),w(bg)
  - M3 ↓ r(bg),w(~bg)
  - M4 ↓ r(~bg),w(bg)
  - M5 ↓ r(bg)
- Each r or w occupies one cycle. In two-op elements the read precedes the write at the same address. ↑ counts 0→addr_max; ↓ counts addr_max→0.
- Per operation, the block drives csb0[sram_sel]=0 (other bits 1), web0=0 for writes and 1 for reads, and din0 = expected word for writes.
- Each read pushes {valid, addr, expected} into an RD_LAT-deep pipeline. On the pipeline output, if sram_dout != expected:
  - fail_count increments (saturating).
  - If this is the first miscompare of the run, fail_addr and fail_data are latched.
- DRAIN lasts RD_LAT cycles with csb0 all ones. Afterwards: DONE, busy=0, done=1, pass=(fail_count==0). DONE→IDLE occurs on the next cycle; done stays high.
- start accepted (IDLE/DONE only):
  - Latches sram_sel, addr_max and pattern.
  - Clears done, pass, fail_addr, fail_data and fail_count.
  - Ignored while busy.
- sram_sel >= MAX_CHIPS: no SRAM access; go directly to DONE with pass=0 and fail_count=16'hFFFF.
- abort while busy: next cycle IDLE, csb0 all ones, busy=0, done=0, pipeline flushed. Status registers keep their partial values.
- start and abort in the same cycle: abort wins.

## Timing
- Reset values: addr0=0, din0=0, web0=1, wmask0=all ones, csb0=all ones, busy=0, done=0, pass=0, fail_addr=0, fail_data=0, fail_count=0.
- start sampled at edge k: busy=1 and the first M0 write is driven in cycle k+1.
- Run length from first op to done=1: 10N + RD_LAT + 1 cycles.
- All outputs are registered.
- Address counter wrap: an element ends at the terminal address and never wraps. addr_max=0 is legal (N=1).
- Reset mid-run: all outputs return to reset values at the next edge.

## Structure
- Shared package `openram_tc_pkg` holds:
  - ADDR_SIZE, DATA_SIZE, WMASK_SIZE, MAX_CHIPS.
  - The march state enum.
  - The op-descriptor struct {read, invert, dir_down}.
- One sub-module, `sram_march_bist_chk`: the RD_LAT expected-data pipeline plus compare and capture logic.

## Test plan
- Clean run, 4 words: addr_max=3, RD_LAT=1, pattern=32'hA5A5A5A5 on a fault-free model → done after 42 cycles, pass=1, fail_count=0, address sequence checked element by element.
- Stuck-at fault: bit0 of address 2 stuck at 1, pattern=0 → pass=0, fail_addr=2, fail_data=32'h00000001, fail_count=3 (reads of bg in M1, M3, M5).
- Abort: abort during M2 → next cycle busy=0, done=0, csb0=16'hFFFF. A following start runs cleanly to pass=1.
- Ignored start: start pulsed mid-run → run length and results unchanged.
- Invalid select: sram_sel=15 with MAX_CHIPS=13 → no csb0 activity, done=1 after 2 cycles, pass=0, fail_count=16'hFFFF.
- Reset mid-M3 and RD_LAT=3 run → outputs return to reset values; the RD_LAT=3 run with addr_max=7 completes in 84 cycles with pass=1.

Source files
------------

// File: rtl/openram_tc_pkg.sv
// Shared definitions for the OpenRAM testchip SRAM blocks: bus sizes,
// march BIST sequencer states and the per-cycle operation descriptor.
package openram_tc_pkg;

  localparam int unsigned ADDR_SIZE  = 16;
  localparam int unsigned DATA_SIZE  = 32;
  localparam int unsigned WMASK_SIZE = 4;
  localparam int unsigned MAX_CHIPS  = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_M0,
    ST_M1,
    ST_M2,
    ST_M3,
    ST_M4,
    ST_M5,
    ST_DRAIN,
    ST_DONE
  } march_state_e;

  typedef struct packed {
    logic read;
    logic invert;
    logic dir_down;
  } march_op_t;

  function automatic logic two_op(input march_state_e st);
    return st inside {ST_M1, ST_M2, ST_M3, ST_M4};
  endfunction

  // March C- table: wr_phase selects the second (write) op of a two-op element.
  function automatic march_op_t march_op(input march_state_e st, input logic wr_phase);
    march_op_t op;
    op = '0;
    case (st)
      ST_M1: begin op.read = !wr_phase; op.invert = wr_phase;  end
      ST_M2: begin op.read = !wr_phase; op.invert = !wr_phase; end
      ST_M3: begin op.read = !wr_phase; op.invert = wr_phase;  op.dir_down = 1'b1; end
      ST_M4: begin op.read = !wr_phase; op.invert = !wr_phase; op.dir_down = 1'b1; end
      ST_M5: begin op.read = 1'b1;      op.dir_down = 1'b1; end
      default: op = '0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/sram_march_bist_chk.sv
// Read-data checker: RD_LAT-deep expected-data pipeline, compare against
// sram_dout, first-fail capture and saturating miscompare counter.
module sram_march_bist_chk #(
  parameter int unsigned ADDR_SIZE = 16,
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic                 clear,
  input  logic                 set_invalid,
  input  logic                 push_vld,
  input  logic [ADDR_SIZE-1:0] push_addr,
  input  logic [DATA_SIZE-1:0] push_exp,
  input  logic [DATA_SIZE-1:0] sram_dout,
  output logic                 miscmp,
  output logic [ADDR_SIZE-1:0] fail_addr,
  output logic [DATA_SIZE-1:0] fail_data,
  output logic [15:0]          fail_count
);

  logic [RD_LAT-1:0]    vld_q;
  logic [ADDR_SIZE-1:0] addr_q [RD_LAT];
  logic [DATA_SIZE-1:0] exp_q  [RD_LAT];
  logic [ADDR_SIZE-1:0] faddr_q;
  logic [DATA_SIZE-1:0] fdata_q;
  logic [15:0]          count_q;

  assign miscmp     = vld_q[RD_LAT-1] && (sram_dout != exp_q[RD_LAT-1]);
  assign fail_addr  = faddr_q;
  assign fail_data  = fdata_q;
  assign fail_count = count_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_q   <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
      count_q <= '0;
    end else begin
      vld_q[0]  <= push_vld && !flush;
      addr_q[0] <= push_addr;
      exp_q[0]  <= push_exp;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1] && !flush;
        addr_q[i] <= addr_q[i-1];
        exp_q[i]  <= exp_q[i-1];
      end
      if (clear) begin
        faddr_q <= '0;
        fdata_q <= '0;
        count_q <= set_invalid ? '1 : '0;
      end else if (miscmp) begin
        if (count_q == '0) begin
          faddr_q <= addr_q[RD_LAT-1];
          fdata_q <= sram_dout;
        end
        if (count_q != '1) count_q <= count_q + 16'd1;
      end
    end
  end

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST sequencer driving the shared OpenRAM port-0 bus for one
// selected macro; read compare and status capture live in the checker.
module sram_march_bist #(
  parameter int unsigned ADDR_SIZE  = openram_tc_pkg::ADDR_SIZE,
  parameter int unsigned DATA_SIZE  = openram_tc_pkg::DATA_SIZE,
  parameter int unsigned WMASK_SIZE = openram_tc_pkg::WMASK_SIZE,
  parameter int unsigned MAX_CHIPS  = openram_tc_pkg::MAX_CHIPS,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [3:0]            sram_sel,
  input  logic [ADDR_SIZE-1:0]  addr_max,
  input  logic [DATA_SIZE-1:0]  pattern,
  input  logic [DATA_SIZE-1:0]  sram_dout,
  output logic [ADDR_SIZE-1:0]  addr0,
  output logic [DATA_SIZE-1:0]  din0,
  output logic                  web0,
  output logic [WMASK_SIZE-1:0] wmask0,
  output logic [MAX_CHIPS-1:0]  csb0,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_SIZE-1:0]  fail_addr,
  output logic [DATA_SIZE-1:0]  fail_data,
  output logic [15:0]           fail_count
);
  import openram_tc_pkg::*;

  march_state_e         state_q, state_d;
  logic                 wr_phase_q, wr_phase_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d, amax_q, amax_d;
  logic [DATA_SIZE-1:0] bg_q, bg_d, din_q, din_d;
  logic [3:0]           sel_q, sel_d;
  logic [1:0]           drain_q, drain_d;
  logic                 web_q, web_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [MAX_CHIPS-1:0] csb_q, csb_d;
  march_op_t            cur_op, nxt_op;
  logic                 elem_last, in_march, miscmp;
  logic                 chk_clear, chk_invalid, chk_flush;

  assign in_march  = state_q inside {ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5};
  assign cur_op    = march_op(state_q, wr_phase_q);
  assign elem_last = (!two_op(state_q) || wr_phase_q) &&
                     (addr_q == (cur_op.dir_down ? '0 : amax_q));

  always_comb begin
    state_d     = state_q;
    wr_phase_d  = wr_phase_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    amax_d      = amax_q;
    bg_d        = bg_q;
    drain_d     = drain_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    chk_clear   = 1'b0;
    chk_invalid = 1'b0;
    chk_flush   = 1'b0;
    if (abort && busy_q) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      chk_flush = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (state_q == ST_DONE) state_d = ST_IDLE;
          if (start) begin
            sel_d     = sram_sel;
            amax_d    = addr_max;
            bg_d      = pattern;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            chk_clear = 1'b1;
            if (32'(sram_sel) >= MAX_CHIPS) begin
              state_d     = ST_DONE;
              done_d      = 1'b1;
              chk_invalid = 1'b1;
            end else begin
              state_d    = ST_M0;
              addr_d     = '0;
              wr_phase_d = 1'b0;
              busy_d     = 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // the last read's compare lands on this same edge
            pass_d  = (fail_count == '0) && !miscmp;
          end else begin
            drain_d = drain_q - 2'd1;
          end
        end
        default: begin
          wr_phase_d = 1'b0;
          if (!elem_last) begin
            if (two_op(state_q) && !wr_phase_q) wr_phase_d = 1'b1;
            else addr_d = cur_op.dir_down ? addr_q - 1'b1 : addr_q + 1'b1;
          end else begin
            case (state_q)
              ST_M0:   begin state_d = ST_M1; addr_d = '0;     end
              ST_M1:   begin state_d = ST_M2; addr_d = '0;     end
              ST_M2:   begin state_d = ST_M3; addr_d = amax_q; end
              ST_M3:   begin state_d = ST_M4; addr_d = amax_q; end
              ST_M4:   begin state_d = ST_M5; addr_d = amax_q; end
              default: begin state_d = ST_DRAIN; drain_d = 2'(RD_LAT - 1); end
            endcase
          end
        end
      endcase
    end
  end

  // Bus drive is derived from the next op so every port-0 signal is registered.
  always_comb begin
    nxt_op = march_op(state_d, wr_phase_d);
    csb_d  = '1;
    web_d  = 1'b1;
    din_d  = din_q;
    if (state_d inside {ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5}) begin
      web_d = nxt_op.read;
      din_d = nxt_op.invert ? ~bg_d : bg_d;
      for (int unsigned i = 0; i < MAX_CHIPS; i++)
        if (i == 32'(sel_d)) csb_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      wr_phase_q <= 1'b0;
      addr_q     <= '0;
      amax_q     <= '0;
      bg_q       <= '0;
      din_q      <= '0;
      sel_q      <= '0;
      drain_q    <= '0;
      web_q      <= 1'b1;
      csb_q      <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_phase_q <= wr_phase_d;
      addr_q     <= addr_d;
      amax_q     <= amax_d;
      bg_q       <= bg_d;
      din_q      <= din_d;
      sel_q      <= sel_d;
      drain_q    <= drain_d;
      web_q      <= web_d;
      csb_q      <= csb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  sram_march_bist_chk #(
    .ADDR_SIZE(ADDR_SIZE),
    .DATA_SIZE(DATA_SIZE),
    .RD_LAT   (RD_LAT)
  ) u_chk (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (chk_flush),
    .clear      (chk_clear),
    .set_invalid(chk_invalid),
    .push_vld   (in_march && web_q),
    .push_addr  (addr_q),
    .push_exp   (din_q),
    .sram_dout  (sram_dout),
    .miscmp     (miscmp),
    .fail_addr  (fail_addr),
    .fail_data  (fail_data),
    .fail_count (fail_count)
  );

  assign addr0  = addr_q;
  assign din0   = din_q;
  assign web0   = web_q;
  assign wmask0 = '1;
  assign csb0   = csb_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign pass   = pass_q;

endmodule
